// File: rtl/rvc_asap_imem_loader.sv
// Streams a program into rvc_asap instruction memory, then holds the core in reset
// for RST_HOLD cycles before releasing it.
module rvc_asap_imem_loader #(
  parameter int unsigned I_MEM_MSB = 16383,
  parameter int unsigned RST_HOLD  = 4
) (
  input  logic                             Clock,
  input  logic                             Rst,
  input  logic                             LoadStart,
  input  logic [15:0]                      LoadLen,
  input  logic                             InValid,
  input  logic [31:0]                      InData,
  output logic                             InReady,
  output logic                             MemWrEn,
  output logic [$clog2(I_MEM_MSB+1)-1:0]   MemWrAddr,
  output logic [31:0]                      MemWrData,
  output logic                             CoreRst,
  output logic                             Done,
  output logic                             Error,
  output logic [31:0]                      Checksum
);

  localparam int unsigned AW        = $clog2(I_MEM_MSB + 1);
  localparam int unsigned MEM_BYTES = I_MEM_MSB + 1;
  localparam logic [7:0]  HOLD_LAST = 8'(RST_HOLD - 1);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, RUN} state_t;

  state_t      state;
  logic [15:0] wcnt;
  logic [15:0] len;
  logic [7:0]  hcnt;
  logic        too_long;

  assign too_long = 32'({LoadLen, 2'b00}) > MEM_BYTES;

  // Memory write port is driven straight from the accepted input word; reset blocks it.
  assign MemWrEn   = InReady && InValid && !Rst;
  assign MemWrAddr = {wcnt[AW-3:0], 2'b00};
  assign MemWrData = InData;

  always_ff @(posedge Clock) begin
    if (Rst) begin
      state    <= IDLE;
      InReady  <= 1'b0;
      CoreRst  <= 1'b1;
      Done     <= 1'b0;
      Error    <= 1'b0;
      Checksum <= '0;
      wcnt     <= '0;
      len      <= '0;
      hcnt     <= '0;
    end else begin
      case (state)
        IDLE, RUN: begin
          if (LoadStart) begin
            if (too_long) begin
              Error <= 1'b1;
            end else begin
              Error    <= 1'b0;
              Checksum <= '0;
              wcnt     <= '0;
              hcnt     <= '0;
              len      <= LoadLen;
              CoreRst  <= 1'b1;
              Done     <= 1'b0;
              if (LoadLen != 16'd0) begin
                state   <= LOAD;
                InReady <= 1'b1;
              end else begin
                state <= HOLD;
              end
            end
          end
        end
        LOAD: begin
          if (InValid) begin
            wcnt     <= wcnt + 16'd1;
            Checksum <= Checksum + InData;
            if (wcnt == len - 16'd1) begin
              state   <= HOLD;
              InReady <= 1'b0;
            end
          end
        end
        HOLD: begin
          // hcnt runs 0..RST_HOLD-1, one HOLD cycle per value.
          if (hcnt == HOLD_LAST) begin
            state   <= RUN;
            CoreRst <= 1'b0;
            Done    <= 1'b1;
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rvc_asap_imem_loader.sv
// Directed bench for rvc_asap_imem_loader: load, stalls, range errors, zero length,
// mid-load reset and reload from RUN.
module tb_rvc_asap_imem_loader;

  logic        Clock;
  logic        Rst;
  logic        LoadStart;
  logic [15:0] LoadLen;
  logic        InValid;
  logic [31:0] InData;
  logic        InReady;
  logic        MemWrEn;
  logic [13:0] MemWrAddr;
  logic [31:0] MemWrData;
  logic        CoreRst;
  logic        Done;
  logic        Error;
  logic [31:0] Checksum;

  int total = 0;
  int bad   = 0;

  logic [13:0] wa [64];
  logic [31:0] wd [64];
  int          wr_n = 0;

  rvc_asap_imem_loader dut (
    .Clock(Clock), .Rst(Rst), .LoadStart(LoadStart), .LoadLen(LoadLen),
    .InValid(InValid), .InData(InData), .InReady(InReady), .MemWrEn(MemWrEn),
    .MemWrAddr(MemWrAddr), .MemWrData(MemWrData), .CoreRst(CoreRst), .Done(Done),
    .Error(Error), .Checksum(Checksum)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Write log, sampled mid-cycle when the combinational write port has settled.
  always @(negedge Clock) begin
    if (MemWrEn === 1'b1) begin
      if (wr_n < 64) begin
        wa[wr_n] = MemWrAddr;
        wd[wr_n] = MemWrData;
      end
      wr_n++;
    end
  end

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset();
    Rst = 1'b1;
    tick();
    tick();
    Rst = 1'b0;
  endtask

  task automatic start_load(input logic [15:0] len_i);
    LoadStart = 1'b1;
    LoadLen   = len_i;
    tick();
    LoadStart = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    InValid = 1'b1;
    InData  = w;
    tick();
    InValid = 1'b0;
  endtask

  task automatic wait_core_run(output int n);
    n = 0;
    while (CoreRst === 1'b1 && n < 20) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    total++; if (CoreRst !== 1'b1) begin bad++; $display("FAIL reset_corerst got=%b want=1", CoreRst); end
    total++; if (InReady !== 1'b0) begin bad++; $display("FAIL reset_inready got=%b want=0", InReady); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b want=0", Done); end
    total++; if (Error !== 1'b0) begin bad++; $display("FAIL reset_error got=%b want=0", Error); end
    total++; if (Checksum !== 32'h0) begin bad++; $display("FAIL reset_checksum got=%h want=0", Checksum); end
    total++; if (MemWrEn !== 1'b0) begin bad++; $display("FAIL reset_memwren got=%b want=0", MemWrEn); end
  endtask

  task automatic test_back_to_back();
    int base;
    int n;
    do_reset();
    base = wr_n;
    start_load(16'd3);
    total++; if (InReady !== 1'b1) begin bad++; $display("FAIL b2b_inready got=%b want=1", InReady); end
    send_word(32'h00000013);
    send_word(32'h00100093);
    send_word(32'h00208113);
    total++; if (InReady !== 1'b0) begin bad++; $display("FAIL b2b_hold_inready got=%b want=0", InReady); end
    total++; if (CoreRst !== 1'b1) begin bad++; $display("FAIL b2b_hold_corerst got=%b want=1", CoreRst); end
    total++; if (wr_n - base !== 3) begin bad++; $display("FAIL b2b_nwrites got=%0d want=3", wr_n - base); end
    total++; if (wa[base] !== 14'd0 || wa[base+1] !== 14'd4 || wa[base+2] !== 14'd8) begin
      bad++; $display("FAIL b2b_addr got=%0d,%0d,%0d want=0,4,8", wa[base], wa[base+1], wa[base+2]); end
    total++; if (wd[base] !== 32'h00000013 || wd[base+1] !== 32'h00100093 || wd[base+2] !== 32'h00208113) begin
      bad++; $display("FAIL b2b_data got=%h,%h,%h", wd[base], wd[base+1], wd[base+2]); end
    total++; if (Checksum !== 32'h003081B9) begin bad++; $display("FAIL b2b_checksum got=%h want=003081b9", Checksum); end
    wait_core_run(n);
    total++; if (n !== 4) begin bad++; $display("FAIL b2b_hold_len got=%0d want=4", n); end
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL b2b_done got=%b want=1", Done); end
    total++; if (Checksum !== 32'h003081B9) begin bad++; $display("FAIL b2b_checksum_run got=%h want=003081b9", Checksum); end
  endtask

  task automatic test_stall();
    int base;
    int n;
    do_reset();
    base = wr_n;
    start_load(16'd3);
    send_word(32'h00000013);
    // LoadStart during LOAD must be ignored, even with an illegal length.
    LoadStart = 1'b1;
    LoadLen   = 16'd4097;
    #1;
    total++; if (MemWrEn !== 1'b0) begin bad++; $display("FAIL stall_gap0 got=%b want=0", MemWrEn); end
    tick();
    LoadStart = 1'b0;
    #1;
    total++; if (MemWrEn !== 1'b0) begin bad++; $display("FAIL stall_gap1 got=%b want=0", MemWrEn); end
    total++; if (Error !== 1'b0 || InReady !== 1'b1) begin
      bad++; $display("FAIL stall_ignore_start got=err%b rdy%b want=err0 rdy1", Error, InReady); end
    tick();
    send_word(32'h00100093);
    for (int i = 0; i < 2; i++) begin
      #1;
      total++; if (MemWrEn !== 1'b0) begin bad++; $display("FAIL stall_gap2_%0d got=%b want=0", i, MemWrEn); end
      tick();
    end
    send_word(32'h00208113);
    total++; if (wr_n - base !== 3) begin bad++; $display("FAIL stall_nwrites got=%0d want=3", wr_n - base); end
    total++; if (wa[base] !== 14'd0 || wa[base+1] !== 14'd4 || wa[base+2] !== 14'd8) begin
      bad++; $display("FAIL stall_addr got=%0d,%0d,%0d want=0,4,8", wa[base], wa[base+1], wa[base+2]); end
    total++; if (Checksum !== 32'h003081B9) begin bad++; $display("FAIL stall_checksum got=%h want=003081b9", Checksum); end
    wait_core_run(n);
    total++; if (n !== 4 || Done !== 1'b1) begin bad++; $display("FAIL stall_run got=n%0d done%b want=n4 done1", n, Done); end
  endtask

  task automatic test_range();
    int base;
    int n;
    do_reset();
    base = wr_n;
    start_load(16'd4097);
    total++; if (Error !== 1'b1) begin bad++; $display("FAIL range_error got=%b want=1", Error); end
    total++; if (InReady !== 1'b0 || CoreRst !== 1'b1 || Done !== 1'b0) begin
      bad++; $display("FAIL range_idle got=rdy%b crst%b done%b want=rdy0 crst1 done0", InReady, CoreRst, Done); end
    InValid = 1'b1;
    InData  = 32'hCAFEF00D;
    #1;
    total++; if (MemWrEn !== 1'b0) begin bad++; $display("FAIL range_nowrite got=%b want=0", MemWrEn); end
    tick();
    InValid = 1'b0;
    start_load(16'd1);
    total++; if (Error !== 1'b0 || InReady !== 1'b1) begin
      bad++; $display("FAIL range_accept got=err%b rdy%b want=err0 rdy1", Error, InReady); end
    send_word(32'hDEADBEEF);
    total++; if (wr_n - base !== 1 || wa[base] !== 14'd0 || wd[base] !== 32'hDEADBEEF) begin
      bad++; $display("FAIL range_write got=n%0d a%0d d%h want=n1 a0 ddeadbeef", wr_n - base, wa[base], wd[base]); end
    total++; if (Checksum !== 32'hDEADBEEF) begin bad++; $display("FAIL range_checksum got=%h want=deadbeef", Checksum); end
    wait_core_run(n);
    total++; if (n !== 4 || Done !== 1'b1) begin bad++; $display("FAIL range_run got=n%0d done%b want=n4 done1", n, Done); end
  endtask

  task automatic test_zero_len();
    int base;
    int n;
    do_reset();
    base = wr_n;
    start_load(16'd0);
    total++; if (InReady !== 1'b0 || CoreRst !== 1'b1 || Error !== 1'b0) begin
      bad++; $display("FAIL zero_hold got=rdy%b crst%b err%b want=rdy0 crst1 err0", InReady, CoreRst, Error); end
    wait_core_run(n);
    total++; if (n !== 4) begin bad++; $display("FAIL zero_hold_len got=%0d want=4", n); end
    total++; if (Done !== 1'b1 || Checksum !== 32'h0) begin
      bad++; $display("FAIL zero_run got=done%b sum%h want=done1 sum0", Done, Checksum); end
    total++; if (wr_n - base !== 0) begin bad++; $display("FAIL zero_nwrites got=%0d want=0", wr_n - base); end
  endtask

  task automatic test_reset_mid_load();
    int base;
    do_reset();
    base = wr_n;
    start_load(16'd3);
    send_word(32'h00000013);
    send_word(32'h00100093);
    Rst     = 1'b1;
    InValid = 1'b1;
    InData  = 32'h00208113;
    #1;
    total++; if (MemWrEn !== 1'b0) begin bad++; $display("FAIL midrst_wren got=%b want=0", MemWrEn); end
    tick();
    Rst = 1'b0;
    total++; if (InReady !== 1'b0 || CoreRst !== 1'b1 || Done !== 1'b0) begin
      bad++; $display("FAIL midrst_idle got=rdy%b crst%b done%b want=rdy0 crst1 done0", InReady, CoreRst, Done); end
    total++; if (Checksum !== 32'h0) begin bad++; $display("FAIL midrst_checksum got=%h want=0", Checksum); end
    #1;
    total++; if (MemWrEn !== 1'b0) begin bad++; $display("FAIL midrst_after got=%b want=0", MemWrEn); end
    tick();
    InValid = 1'b0;
    total++; if (wr_n - base !== 2) begin bad++; $display("FAIL midrst_nwrites got=%0d want=2", wr_n - base); end
  endtask

  task automatic test_reload_in_run();
    int base;
    int n;
    do_reset();
    start_load(16'd1);
    send_word(32'h12345678);
    wait_core_run(n);
    total++; if (Done !== 1'b1) begin bad++; $display("FAIL reload_pre_done got=%b want=1", Done); end
    base = wr_n;
    start_load(16'd4097);
    total++; if (Error !== 1'b1 || Done !== 1'b1 || CoreRst !== 1'b0 || Checksum !== 32'h12345678) begin
      bad++; $display("FAIL reload_reject got=err%b done%b crst%b sum%h", Error, Done, CoreRst, Checksum); end
    start_load(16'd2);
    total++; if (CoreRst !== 1'b1 || Done !== 1'b0 || Error !== 1'b0) begin
      bad++; $display("FAIL reload_start got=crst%b done%b err%b want=crst1 done0 err0", CoreRst, Done, Error); end
    total++; if (Checksum !== 32'h0 || InReady !== 1'b1) begin
      bad++; $display("FAIL reload_clear got=sum%h rdy%b want=sum0 rdy1", Checksum, InReady); end
    send_word(32'hFFFFFFFF);
    send_word(32'h00000002);
    total++; if (wr_n - base !== 2 || wa[base] !== 14'd0 || wa[base+1] !== 14'd4) begin
      bad++; $display("FAIL reload_addr got=n%0d %0d,%0d want=n2 0,4", wr_n - base, wa[base], wa[base+1]); end
    total++; if (Checksum !== 32'h00000001) begin bad++; $display("FAIL reload_checksum_wrap got=%h want=00000001", Checksum); end
    wait_core_run(n);
    total++; if (n !== 4 || Done !== 1'b1) begin bad++; $display("FAIL reload_run got=n%0d done%b want=n4 done1", n, Done); end
    // Largest legal length fills memory exactly and must be accepted.
    start_load(16'd4096);
    total++; if (Error !== 1'b0 || InReady !== 1'b1) begin
      bad++; $display("FAIL reload_maxlen got=err%b rdy%b want=err0 rdy1", Error, InReady); end
    do_reset();
  endtask

  initial begin
    Rst       = 1'b1;
    LoadStart = 1'b0;
    LoadLen   = 16'd0;
    InValid   = 1'b0;
    InData    = 32'h0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_range();
    test_zero_len();
    test_reset_mid_load();
    test_reload_in_run();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
